// File: rtl/echo_msg_serializer_if.sv
// rtl/echo_msg_serializer_if.sv - message-in / word-out handshake bundle for the echo serializer
interface echo_msg_serializer_if;
    logic        pipe_enq_ena;
    logic [95:0] pipe_enq_v;
    logic        pipe_enq_rdy;
    logic        out_enq_ena;
    logic [31:0] out_enq_v;
    logic        out_enq_last;
    logic        out_enq_rdy;

    modport master (
        output pipe_enq_ena, pipe_enq_v, out_enq_rdy,
        input  pipe_enq_rdy, out_enq_ena, out_enq_v, out_enq_last
    );

    modport slave (
        input  pipe_enq_ena, pipe_enq_v, out_enq_rdy,
        output pipe_enq_rdy, out_enq_ena, out_enq_v, out_enq_last
    );
endinterface

// File: rtl/echo_msg_serializer.sv
// rtl/echo_msg_serializer.sv - FIFO of 96-bit messages emitted as three 32-bit words
module echo_msg_serializer #(
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    echo_msg_serializer_if.slave   bus,
    output logic [4:0]             occupancy,
    output logic [31:0]            msg_count
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {WS_IDLE, WS_W0, WS_W1, WS_W2} ws_e;

    logic [95:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    occ_q, occ_d;
    logic [31:0]   msg_count_q, msg_count_d;
    ws_e           ws_q, ws_d;

    logic          enq;
    logic          xfer;
    logic          pop;
    logic [95:0]   head;
    logic [31:0]   word;

    assign head = mem_q[rd_ptr_q];

    // Handshake outputs are forced low while reset is held, independent of state.
    assign bus.pipe_enq_rdy = !nRST && (occ_q < 5'(DEPTH));
    assign bus.out_enq_ena  = !nRST && (ws_q != WS_IDLE) && bus.out_enq_rdy;
    assign bus.out_enq_last = !nRST && (ws_q == WS_W2);
    assign bus.out_enq_v    = nRST ? 32'h0 : word;

    assign enq  = bus.pipe_enq_ena && bus.pipe_enq_rdy;
    assign xfer = bus.out_enq_ena;
    assign pop  = xfer && (ws_q == WS_W2);

    assign occupancy = occ_q;
    assign msg_count = msg_count_q;

    always_comb begin
        word = 32'h0;
        case (ws_q)
            WS_W0:   word = head[95:64];
            WS_W1:   word = head[63:32];
            WS_W2:   word = head[31:0];
            default: word = 32'h0;
        endcase
    end

    always_comb begin
        ws_d        = ws_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        msg_count_d = msg_count_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            msg_count_d = msg_count_q + 32'd1;
        end
        if (enq && !pop) begin
            occ_d = occ_q + 5'd1;
        end else if (!enq && pop) begin
            occ_d = occ_q - 5'd1;
        end

        case (ws_q)
            WS_IDLE: if (enq)  ws_d = WS_W0;
            WS_W0:   if (xfer) ws_d = WS_W1;
            WS_W1:   if (xfer) ws_d = WS_W2;
            // A same-cycle enqueue keeps the word stream gapless when the head was the only entry.
            WS_W2:   if (xfer) ws_d = ((occ_q > 5'd1) || enq) ? WS_W0 : WS_IDLE;
            default: ws_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            ws_q        <= WS_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= 5'd0;
            msg_count_q <= 32'd0;
        end else begin
            ws_q        <= ws_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            msg_count_q <= msg_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= bus.pipe_enq_v;
        end
    end
endmodule

// File: tb/tb_echo_msg_serializer.sv
// tb/tb_echo_msg_serializer.sv - directed self-checking bench for echo_msg_serializer
module tb_echo_msg_serializer;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  occupancy;
    logic [31:0] msg_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    echo_msg_serializer_if bus ();

    echo_msg_serializer #(.DEPTH(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .occupancy (occupancy),
        .msg_count (msg_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic e_ena,
                       input logic [31:0] e_v, input logic e_last);
        bus.out_enq_rdy = rdy;
        #1;
        chk({tag, ".ena"},  96'(bus.out_enq_ena),  96'(e_ena));
        chk({tag, ".v"},    96'(bus.out_enq_v),    96'(e_v));
        chk({tag, ".last"}, 96'(bus.out_enq_last), 96'(e_last));
        tick();
    endtask

    function automatic logic [95:0] smsg(input int i);
        return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i)};
    endfunction

    initial begin
        bus.pipe_enq_ena = 1'b0;
        bus.pipe_enq_v   = 96'h0;
        bus.out_enq_rdy  = 1'b1;
        nRST             = 1'b1;
        tick();
        tick();
        #1;
        chk("rst.pipe_rdy", 96'(bus.pipe_enq_rdy), 96'd0);
        chk("rst.out_ena",  96'(bus.out_enq_ena),  96'd0);
        chk("rst.last",     96'(bus.out_enq_last), 96'd0);
        chk("rst.v",        96'(bus.out_enq_v),    96'd0);
        chk("rst.occ",      96'(occupancy),        96'd0);
        chk("rst.cnt",      96'(msg_count),        96'd0);

        // single message, accepted in the first cycle out of reset
        nRST             = 1'b0;
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'h00000001_0000000A_DEADBEEF;
        #1;
        chk("m1.pipe_rdy", 96'(bus.pipe_enq_rdy), 96'd1);
        tick();
        bus.pipe_enq_ena = 1'b0;
        cyc("m1.w0", 1'b1, 1'b1, 32'h0000_0001, 1'b0);
        cyc("m1.w1", 1'b1, 1'b1, 32'h0000_000A, 1'b0);
        cyc("m1.w2", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("m1.idle", 96'(bus.out_enq_ena), 96'd0);
        chk("m1.cnt",  96'(msg_count),       96'd1);
        chk("m1.occ",  96'(occupancy),       96'd0);

        // downstream ready toggled 1,0,0,1,1
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'h11111111_22222222_33333333;
        tick();
        bus.pipe_enq_ena = 1'b0;
        cyc("hold.0", 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        cyc("hold.1", 1'b0, 1'b0, 32'h2222_2222, 1'b0);
        cyc("hold.2", 1'b0, 1'b0, 32'h2222_2222, 1'b0);
        cyc("hold.3", 1'b1, 1'b1, 32'h2222_2222, 1'b0);
        cyc("hold.4", 1'b1, 1'b1, 32'h3333_3333, 1'b1);
        #1;
        chk("hold.idle", 96'(bus.out_enq_ena), 96'd0);
        chk("hold.cnt",  96'(msg_count),       96'd2);

        // full FIFO rejects the third message
        bus.out_enq_rdy  = 1'b0;
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'hAAAA0001_AAAA0002_AAAA0003;
        #1;
        chk("ovf.rdy_a", 96'(bus.pipe_enq_rdy), 96'd1);
        tick();
        bus.pipe_enq_v = 96'hBBBB0001_BBBB0002_BBBB0003;
        #1;
        chk("ovf.rdy_b", 96'(bus.pipe_enq_rdy), 96'd1);
        tick();
        bus.pipe_enq_v = 96'hCCCC0001_CCCC0002_CCCC0003;
        #1;
        chk("ovf.rdy_c", 96'(bus.pipe_enq_rdy), 96'd0);
        tick();
        bus.pipe_enq_ena = 1'b0;
        #1;
        chk("ovf.occ",     96'(occupancy),       96'd2);
        chk("ovf.out_ena", 96'(bus.out_enq_ena), 96'd0);
        cyc("ovf.a0", 1'b1, 1'b1, 32'hAAAA_0001, 1'b0);
        cyc("ovf.a1", 1'b1, 1'b1, 32'hAAAA_0002, 1'b0);
        cyc("ovf.a2", 1'b1, 1'b1, 32'hAAAA_0003, 1'b1);
        cyc("ovf.b0", 1'b1, 1'b1, 32'hBBBB_0001, 1'b0);
        cyc("ovf.b1", 1'b1, 1'b1, 32'hBBBB_0002, 1'b0);
        cyc("ovf.b2", 1'b1, 1'b1, 32'hBBBB_0003, 1'b1);
        cyc("ovf.idle0", 1'b1, 1'b0, 32'h0, 1'b0);
        cyc("ovf.idle1", 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ovf.cnt", 96'(msg_count), 96'd4);
        chk("ovf.occ_end", 96'(occupancy), 96'd0);

        // 10-message stream, each new message enqueued on the cycle the previous one pops
        for (int t = 0; t <= 30; t++) begin
            bus.pipe_enq_ena = ((t % 3) == 0) && (t < 30);
            bus.pipe_enq_v   = smsg(t / 3);
            if (bus.pipe_enq_ena) begin
                #1;
                chk($sformatf("str.rdy%0d", t), 96'(bus.pipe_enq_rdy), 96'd1);
            end
            if (t == 0) begin
                cyc("str.t0", 1'b1, 1'b0, 32'h0, 1'b0);
            end else begin
                chk($sformatf("str.occ%0d", t), 96'(occupancy), 96'd1);
                cyc($sformatf("str.t%0d", t), 1'b1, 1'b1,
                    32'h1000_0000 * 32'(((t - 1) % 3) + 1) + 32'((t - 1) / 3),
                    ((t - 1) % 3) == 2);
            end
        end
        bus.pipe_enq_ena = 1'b0;
        #1;
        chk("str.idle", 96'(bus.out_enq_ena), 96'd0);
        chk("str.cnt",  96'(msg_count),       96'd14);
        chk("str.occ",  96'(occupancy),       96'd0);

        // reset in W1 with two messages queued
        bus.out_enq_rdy  = 1'b0;
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'hD0D0_0001_D0D0_0002_D0D0_0003;
        tick();
        bus.pipe_enq_v = 96'hE0E0_0001_E0E0_0002_E0E0_0003;
        tick();
        bus.pipe_enq_ena = 1'b0;
        chk("mr.occ2", 96'(occupancy), 96'd2);
        cyc("mr.w0", 1'b1, 1'b1, 32'hD0D0_0001, 1'b0);
        nRST            = 1'b1;
        bus.out_enq_rdy = 1'b1;
        #1;
        chk("mr.ena_in_rst", 96'(bus.out_enq_ena),  96'd0);
        chk("mr.rdy_in_rst", 96'(bus.pipe_enq_rdy), 96'd0);
        chk("mr.v_in_rst",   96'(bus.out_enq_v),    96'd0);
        tick();
        chk("mr.ena", 96'(bus.out_enq_ena), 96'd0);
        chk("mr.occ", 96'(occupancy),       96'd0);
        chk("mr.cnt", 96'(msg_count),       96'd0);
        nRST             = 1'b0;
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'hF0F0_0001_F0F0_0002_F0F0_0003;
        tick();
        bus.pipe_enq_ena = 1'b0;
        cyc("mr.z0", 1'b1, 1'b1, 32'hF0F0_0001, 1'b0);
        cyc("mr.z1", 1'b1, 1'b1, 32'hF0F0_0002, 1'b0);
        cyc("mr.z2", 1'b1, 1'b1, 32'hF0F0_0003, 1'b1);
        cyc("mr.idle0", 1'b1, 1'b0, 32'h0, 1'b0);
        cyc("mr.idle1", 1'b1, 1'b0, 32'h0, 1'b0);
        cyc("mr.idle2", 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mr.cnt1", 96'(msg_count), 96'd1);

        // completion counter wrap
        force dut.msg_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.msg_count_q;
        #1;
        chk("wrap.pre", 96'(msg_count), 96'hFFFF_FFFF);
        bus.pipe_enq_ena = 1'b1;
        bus.pipe_enq_v   = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
        tick();
        bus.pipe_enq_ena = 1'b0;
        cyc("wrap.w0", 1'b1, 1'b1, 32'h0123_4567, 1'b0);
        cyc("wrap.w1", 1'b1, 1'b1, 32'h89AB_CDEF, 1'b0);
        cyc("wrap.w2", 1'b1, 1'b1, 32'h0F1E_2D3C, 1'b1);
        #1;
        chk("wrap.cnt", 96'(msg_count), 96'd0);
        chk("wrap.occ", 96'(occupancy), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/echo_msg_serializer.md
ECHO_MSG_SERIALIZER -- requirements
Module: echo_msg_serializer

Interface
REQ-001 Parameter DEPTH, default 2, message FIFO entries; legal values 2, 4, 8, 16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-high; name kept for codebase consistency.
REQ-004 pipe$enq__ENA  input  1  upstream enqueue strobe for one packed message.
REQ-005 pipe$enq_v  input  96  message: [95:64] tag, [63:32] meth, [31:0] v.
REQ-006 pipe$enq__RDY  output  1  block can accept a message this cycle.
REQ-007 out$enq__ENA  output  1  one 32-bit word transferred downstream this cycle.
REQ-008 out$enq_v  output  32  current word.
REQ-009 out$enq_last  output  1  current word is the final word of its message.
REQ-010 out$enq__RDY  input  1  downstream can accept a word this cycle.
REQ-011 occupancy  output  5  messages held in FIFO, including the one being serialized.
REQ-012 msg_count  output  32  messages fully emitted since reset.

Function
REQ-013 Enqueue occurs in a cycle where pipe$enq__ENA=1 and pipe$enq__RDY=1; pipe$enq__ENA while pipe$enq__RDY=0 is ignored, with no state change.
REQ-014 pipe$enq__RDY = (occupancy < DEPTH) and not in reset; no bypass: full FIFO rejects even if a pop happens the same cycle.
REQ-015 FIFO is circular; read and write pointers wrap modulo DEPTH; messages leave in arrival order.
REQ-016 Word selector ws has states IDLE, W0, W1, W2.
REQ-017 IDLE: FIFO empty; out$enq__ENA=0; moves to W0 on the cycle after the first enqueue into an empty FIFO.
REQ-018 W0/W1/W2 present head-entry bits [95:64], [63:32], [31:0] respectively on out$enq_v.
REQ-019 out$enq__ENA = (ws != IDLE) and out$enq__RDY; out$enq__ENA never high while out$enq__RDY is low.
REQ-020 On transfer, W0->W1 and W1->W2; with out$enq__RDY low, ws and out$enq_v hold.
REQ-021 out$enq_last=1 only in W2.
REQ-022 Transfer in W2 pops head, increments msg_count (wraps 0xFFFFFFFF->0), then ws->W0 if another message remains, else IDLE.
REQ-023 Simultaneous enqueue and W2 pop: occupancy unchanged; with occupancy 1 beforehand, the new message starts at W0 next cycle with no IDLE gap.
REQ-024 Latency: message enqueued into empty FIFO in cycle N presents word0 in cycle N+1; a steady stream with out$enq__RDY=1 gives 1 word/cycle, 3 cycles/message.
REQ-025 occupancy = enqueues minus pops, range 0..DEPTH.
REQ-026 out$enq_v is a registered/muxed view of FIFO storage only; it does not depend combinationally on pipe$enq_v.

Reset
REQ-027 While nRST=1 at a rising edge: pointers, occupancy, msg_count cleared to 0; ws=IDLE.
REQ-028 During reset, pipe$enq__RDY=0, out$enq__ENA=0, out$enq_last=0, out$enq_v=0.
REQ-029 Reset mid-message discards all stored and partially emitted messages, with no further words for them after reset release.
REQ-030 FIFO data storage needs no reset.
REQ-031 First enqueue is accepted in the first cycle with nRST=0.

Verification
REQ-032 Single message 0x00000001_0000000A_DEADBEEF, out$enq__RDY=1 -> words 0x00000001, 0x0000000A, 0xDEADBEEF on cycles N+1..N+3; last only on third; msg_count=1; occupancy back to 0.
REQ-033 DEPTH=2, out$enq__RDY=0, three back-to-back enqueues -> first two accepted; pipe$enq__RDY=0 on third; occupancy=2; third message never emitted.
REQ-034 out$enq__RDY toggled 1,0,0,1,1 during one message -> words are held while RDY is low; exactly 3 transfers in order; no duplicates.
REQ-035 Continuous stream of 10 messages with out$enq__RDY=1 -> 30 consecutive transfer cycles with no gap; msg_count=10; FIFO order preserved.
REQ-036 Assert nRST during W1 with 2 messages queued -> next cycle out$enq__ENA=0, occupancy=0, msg_count=0; a new message after release emits its own words only.
REQ-037 Preload msg_count near wrap by 2^32-1 completions (or force) -> next completion gives msg_count=0.
